seq_multiply: RTL and testbench



---
 rtl/seq_multiply.sv | 126 ++++++++++++
 tb/tb_seq_multiply.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seq_multiply.sv
// Iterative signed multiplier: magnitudes are multiplied MSB-first, one multiplier
// bit per clock, and the sign is applied in a final fix-up cycle.
module seq_multiply #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] multiplicand,
  input  logic [BITS-1:0] multiplier,
  input  logic            input_vld,
  output logic            output_vld,
  output logic [BITS-1:0] product,
  output logic [BITS-1:0] product_hi,
  output logic            overflow
);

  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int PW = 2 * BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_e;

  state_e            state_q, state_d;
  logic [BITS-1:0]   abs_a_q, abs_a_d;
  logic [BITS-1:0]   abs_b_q, abs_b_d;
  logic              sign_q, sign_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BITS-1:0]   prod_lo_q, prod_lo_d;
  logic [BITS-1:0]   prod_hi_q, prod_hi_d;
  logic              ovf_q, ovf_d;

  logic [BITS-1:0]   abs_a_in, abs_b_in;
  logic [PW-1:0]     addend;
  logic [PW-1:0]     full;
  logic [BITS:0]     top_bits;

  // The most negative operand negates to 2^(BITS-1), which still fits as unsigned.
  assign abs_a_in = multiplicand[BITS-1] ? (~multiplicand + BITS'(1)) : multiplicand;
  assign abs_b_in = multiplier[BITS-1]   ? (~multiplier   + BITS'(1)) : multiplier;

  assign addend   = abs_b_q[cnt_q] ? {{BITS{1'b0}}, abs_a_q} : '0;
  assign full     = sign_q ? (~acc_q + PW'(1)) : acc_q;
  // Representable iff the top BITS+1 bits are a pure sign extension.
  assign top_bits = full[PW-1:BITS-1];

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    abs_a_d   = abs_a_q;
    abs_b_d   = abs_b_q;
    sign_d    = sign_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    prod_lo_d = prod_lo_q;
    prod_hi_d = prod_hi_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (input_vld) begin
          abs_a_d = abs_a_in;
          abs_b_d = abs_b_in;
          sign_d  = multiplicand[BITS-1] ^ multiplier[BITS-1];
          acc_d   = '0;
          cnt_d   = CW'(BITS - 1);
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        acc_d = {acc_q[PW-2:0], 1'b0} + addend;
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_FIX: begin
        prod_lo_d = full[BITS-1:0];
        prod_hi_d = full[PW-1:BITS];
        ovf_d     = !((&top_bits) || !(|top_bits));
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; reset here is synchronous and wins over any transfer.
    if (rst) begin
      state_q   <= S_IDLE;
      abs_a_q   <= '0;
      abs_b_q   <= '0;
      sign_q    <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      prod_lo_q <= '0;
      prod_hi_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      abs_a_q   <= abs_a_d;
      abs_b_q   <= abs_b_d;
      sign_q    <= sign_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      prod_lo_q <= prod_lo_d;
      prod_hi_q <= prod_hi_d;
      ovf_q     <= ovf_d;
    end
  end

  assign output_vld = (state_q == S_IDLE);
  assign product    = prod_lo_q;
  assign product_hi = prod_hi_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_seq_multiply.sv
// Bench for seq_multiply: a transaction-level model (64-bit arithmetic plus a
// busy countdown) is compared every cycle, with literal checks after each operation.
module tb_seq_multiply;

  localparam int     BITS = 32;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic            clk;
  logic            rst;
  logic [BITS-1:0] multiplicand;
  logic [BITS-1:0] multiplier;
  logic            input_vld;
  logic            output_vld;
  logic [BITS-1:0] product;
  logic [BITS-1:0] product_hi;
  logic            overflow;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  int          m_left = 0;
  longint      m_pend = 0;
  logic [31:0] m_lo   = '0;
  logic [31:0] m_hi   = '0;
  logic        m_ovf  = 1'b0;

  seq_multiply #(.BITS(BITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .input_vld    (input_vld),
    .output_vld   (output_vld),
    .product      (product),
    .product_hi   (product_hi),
    .overflow     (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint model_full(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  // Reference: an accepted request yields the exact signed product BITS+1 clocks later.
  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0;
      m_lo   <= '0;
      m_hi   <= '0;
      m_ovf  <= 1'b0;
    end else if (m_left == 0) begin
      if (input_vld) begin
        m_pend <= model_full(multiplicand, multiplier);
        m_left <= BITS + 1;
      end
    end else begin
      if (m_left == 1) begin
        m_lo  <= m_pend[31:0];
        m_hi  <= m_pend[63:32];
        m_ovf <= (m_pend > MAXV) || (m_pend < MINV);
      end
      m_left <= m_left - 1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("cyc_vld", {63'd0, output_vld}, {63'd0, (m_left == 0)});
      if (m_left == 0) begin
        check("cyc_lo",  {32'd0, product},    {32'd0, m_lo});
        check("cyc_hi",  {32'd0, product_hi}, {32'd0, m_hi});
        check("cyc_ovf", {63'd0, overflow},   {63'd0, m_ovf});
      end
    end
  end

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    input_vld    = 1'b1;
    @(negedge clk);
    input_vld    = 1'b0;
  endtask

  task automatic wait_done(input string name, output int cycles);
    cycles = 0;
    while (!output_vld && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    check({name, "_done"}, {63'd0, output_vld}, 64'd1);
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        input logic exp_ovf);
    int lat;
    start(a, b);
    wait_done(name, lat);
    check({name, "_lat"}, 64'(lat), 64'd33);
    check({name, "_lo"},  {32'd0, product},    {32'd0, exp_lo});
    check({name, "_hi"},  {32'd0, product_hi}, {32'd0, exp_hi});
    check({name, "_ovf"}, {63'd0, overflow},   {63'd0, exp_ovf});
  endtask

  initial begin
    int lat;
    rst          = 1'b1;
    input_vld    = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (2) @(negedge clk);
    check("rst_vld", {63'd0, output_vld}, 64'd1);
    check("rst_lo",  {32'd0, product},    64'd0);
    check("rst_hi",  {32'd0, product_hi}, 64'd0);
    check("rst_ovf", {63'd0, overflow},   64'd0);
    rst      = 1'b0;
    check_en = 1'b1;

    run_op("pos_neg",  32'd7,          32'hFFFFFFFA, 32'hFFFFFFD6, 32'hFFFFFFFF, 1'b0);
    run_op("min_m1",   32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b1);
    run_op("two32",    32'h00010000,   32'h00010000, 32'h00000000, 32'h00000001, 1'b1);
    run_op("zero",     32'd0,          32'hFFFFFFFB, 32'h00000000, 32'h00000000, 1'b0);
    run_op("m1_m1",    32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
    run_op("min_min",  32'h80000000,   32'h80000000, 32'h00000000, 32'h40000000, 1'b1);
    run_op("max_max",  32'h7FFFFFFF,   32'h7FFFFFFF, 32'h00000001, 32'h3FFFFFFF, 1'b1);
    run_op("min_one",  32'h80000000,   32'd1,        32'h80000000, 32'hFFFFFFFF, 1'b0);

    // A request while busy must be dropped, not queued.
    start(32'd3, 32'd4);
    repeat (9) @(negedge clk);
    multiplicand = 32'd100;
    multiplier   = 32'd100;
    input_vld    = 1'b1;
    @(negedge clk);
    input_vld    = 1'b0;
    wait_done("ignore", lat);
    check("ignore_lat", 64'(lat), 64'd23);
    check("ignore_lo",  {32'd0, product}, 64'd12);
    repeat (3) @(negedge clk);
    check("ignore_noq", {63'd0, output_vld}, 64'd1);

    // Reset in the middle of an operation discards it.
    start(32'd5, 32'd5);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_vld", {63'd0, output_vld}, 64'd1);
    check("midrst_lo",  {32'd0, product},    64'd0);
    check("midrst_hi",  {32'd0, product_hi}, 64'd0);
    check("midrst_ovf", {63'd0, overflow},   64'd0);
    run_op("after_rst", 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFA, 32'hFFFFFFFF, 1'b0);

    // Back-to-back: with input_vld held, idle lasts exactly one cycle between runs.
    @(negedge clk);
    multiplicand = 32'd9;
    multiplier   = 32'd9;
    input_vld    = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      wait_done("b2b", lat);
      check("b2b_lat", 64'(lat), 64'd33);
      check("b2b_lo",  {32'd0, product}, 64'd81);
      @(negedge clk);
      check("b2b_gap", {63'd0, output_vld}, 64'd0);
    end
    input_vld = 1'b0;
    wait_done("b2b_last", lat);
    check("b2b_last_lo", {32'd0, product}, 64'd81);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
